// File: rtl/od_mon_pkg.sv
// -----------------------------------------------------------------------------
// od_mon_pkg
// Shared constants and helpers for the open-drain line monitor.
//   IDLE_LEVEL      level of an undriven line (pulled up)
//   CHAIN_PER_LINE  shift-chain bits contributed by each line:
//                   2 = {FALL, LEVEL}, 3 = {RISE, FALL, LEVEL}
//   filt_cnt_w()    width of the per-line filter counter
// Configuration macro: OD_MON_RISE_EN (adds sticky rising-edge flags).
// -----------------------------------------------------------------------------
package od_mon_pkg;

  localparam logic IDLE_LEVEL = 1'b1;

`ifdef OD_MON_RISE_EN
  localparam int CHAIN_PER_LINE = 3;
`else
  localparam int CHAIN_PER_LINE = 2;
`endif

  // ceil(log2(filter)), never less than one bit so FILTER=1 still has a counter.
  function automatic int filt_cnt_w(input int filter);
    return (filter <= 2) ? 1 : $clog2(filter);
  endfunction

endpackage

// File: rtl/od_line_filter.sv
// -----------------------------------------------------------------------------
// od_line_filter
// One monitored line: 2-flop synchronizer, stability filter and edge pulses.
// The filtered level only follows the synchronized input after FILTER
// consecutive disagreeing cycles; any agreeing cycle restarts the count.
// Ports:
//   CLK      clock, rising edge
//   CLR_N    asynchronous active-low reset
//   i_y      raw line level
//   o_level  filtered level
//   o_fall   one-cycle pulse, true while the next edge commits a 1->0
//   o_rise   (OD_MON_RISE_EN only) same for 0->1
// Parameters: FILTER, legal range 1..15.
// -----------------------------------------------------------------------------
module od_line_filter
  import od_mon_pkg::*;
#(
  parameter int FILTER = 4
) (
  input  logic CLK,
  input  logic CLR_N,
  input  logic i_y,
  output logic o_level,
`ifdef OD_MON_RISE_EN
  output logic o_rise,
`endif
  output logic o_fall
);

  localparam int              CW       = filt_cnt_w(FILTER);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER - 1);

  logic          r_s1;
  logic          r_s;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_commit;

  // The level flips on the edge where the last required disagreeing cycle
  // is counted, so the counter tops out at FILTER-1.
  assign w_commit = (r_s != r_level) && (r_cnt == CNT_LAST);

  // NOTE: every state element uses <= so all flops sample pre-edge values;
  // a blocking = here would let r_s see the new r_s1 in the same edge.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_s1    <= IDLE_LEVEL;
      r_s     <= IDLE_LEVEL;
      r_level <= IDLE_LEVEL;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_y;
      r_s  <= r_s1;
      if (r_s == r_level) begin
        r_cnt <= '0;
      end else if (w_commit) begin
        r_level <= r_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = w_commit & ~r_s;
`ifdef OD_MON_RISE_EN
  assign o_rise  = w_commit &  r_s;
`endif

endmodule

// File: rtl/od_line_monitor.sv
// -----------------------------------------------------------------------------
// od_line_monitor
// N-line receiver for wired-AND open-drain lines. Each line is synchronized
// and glitch-filtered; falling edges set sticky flags. Levels and flags are
// captured into a 74x165-style load/shift register for three-wire polling.
// Ports:
//   CLK    clock, rising edge
//   CLR_N  asynchronous active-low reset
//   Y      raw line levels (idle high)
//   LD     parallel load of {flags, LEVEL} into the shift register; clears
//          the sticky flags (a flag set on the same edge survives)
//   SH     shift enable (LD has priority)
//   SI     serial input for cascading
//   Q      serial output, shift register MSB
//   LEVEL  filtered levels
//   FALL   sticky falling-edge flags
//   RISE   sticky rising-edge flags (OD_MON_RISE_EN only)
// Configuration macro: OD_MON_RISE_EN -> RISE flags, chain {RISE, FALL, LEVEL}.
// Default build chain is {FALL, LEVEL}, FALL[N-1] at the MSB.
// -----------------------------------------------------------------------------
module od_line_monitor
  import od_mon_pkg::*;
#(
  parameter int N      = 6,
  parameter int FILTER = 4
) (
  input  logic         CLK,
  input  logic         CLR_N,
  input  logic [N-1:0] Y,
  input  logic         LD,
  input  logic         SH,
  input  logic         SI,
  output logic         Q,
  output logic [N-1:0] LEVEL,
`ifdef OD_MON_RISE_EN
  output logic [N-1:0] RISE,
`endif
  output logic [N-1:0] FALL
);

  localparam int CHAIN = CHAIN_PER_LINE * N;

  logic [N-1:0]     w_fall_pulse;
  logic [N-1:0]     r_fall;
  logic [CHAIN-1:0] r_shreg;
  logic [CHAIN-1:0] w_shreg_next;
  logic [CHAIN-1:0] w_snapshot;
`ifdef OD_MON_RISE_EN
  logic [N-1:0]     w_rise_pulse;
  logic [N-1:0]     r_rise;
`endif

  for (genvar gi = 0; gi < N; gi++) begin : g_line
    od_line_filter #(
      .FILTER (FILTER)
    ) u_line (
      .CLK     (CLK),
      .CLR_N   (CLR_N),
      .i_y     (Y[gi]),
      .o_level (LEVEL[gi]),
`ifdef OD_MON_RISE_EN
      .o_rise  (w_rise_pulse[gi]),
`endif
      .o_fall  (w_fall_pulse[gi])
    );
  end

`ifdef OD_MON_RISE_EN
  assign w_snapshot = {r_rise, r_fall, LEVEL};
`else
  assign w_snapshot = {r_fall, LEVEL};
`endif

  // NOTE: w_shreg_next gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    w_shreg_next = r_shreg;
    if (LD) begin
      w_shreg_next = w_snapshot;
    end else if (SH) begin
      w_shreg_next = {r_shreg[CHAIN-2:0], SI};
    end
  end

  // LD clears the flags, but an edge committing on the same clock sets its
  // flag again so no event is lost between snapshot and clear.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_fall  <= '0;
      r_shreg <= '0;
    end else begin
      r_fall  <= (LD ? '0 : r_fall) | w_fall_pulse;
      r_shreg <= w_shreg_next;
    end
  end

`ifdef OD_MON_RISE_EN
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_rise <= '0;
    end else begin
      r_rise <= (LD ? '0 : r_rise) | w_rise_pulse;
    end
  end

  assign RISE = r_rise;
`endif

  assign FALL = r_fall;
  assign Q    = r_shreg[CHAIN-1];

endmodule

// File: tb/tb_od_line_monitor.sv
// -----------------------------------------------------------------------------
// tb_od_line_monitor
// Self-checking bench for od_line_monitor (N=6, FILTER=4). Honours
// OD_MON_RISE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_od_line_monitor;
  import od_mon_pkg::*;

  localparam int N      = 6;
  localparam int FILTER = 4;
  localparam int CH     = CHAIN_PER_LINE * N;

  logic         CLK;
  logic         CLR_N;
  logic [N-1:0] Y;
  logic         LD;
  logic         SH;
  logic         SI;
  logic         Q;
  logic [N-1:0] LEVEL;
  logic [N-1:0] FALL;
`ifdef OD_MON_RISE_EN
  logic [N-1:0] RISE;
`endif

  od_line_monitor #(
    .N      (N),
    .FILTER (FILTER)
  ) dut (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .Y     (Y),
    .LD    (LD),
    .SH    (SH),
    .SI    (SI),
    .Q     (Q),
    .LEVEL (LEVEL),
`ifdef OD_MON_RISE_EN
    .RISE  (RISE),
`endif
    .FALL  (FALL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- reference model ----------------
  // Each line: the synchronized value is Y from two edges earlier; the level
  // follows it once it has disagreed for FILTER evaluations in a row.
  logic [N-1:0]  m_s1, m_s, m_level, m_fall, m_rise;
  int            m_run [N];
  logic [CH-1:0] m_sh;

  task automatic model_reset();
    m_s1    = '1;
    m_s     = '1;
    m_level = '1;
    m_fall  = '0;
    m_rise  = '0;
    m_sh    = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] nl, fp, rp;
    nl = m_level;
    fp = '0;
    rp = '0;
    for (int i = 0; i < N; i++) begin
      if (m_s[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == FILTER) begin
          nl[i]    = m_s[i];
          m_run[i] = 0;
          if (m_s[i]) rp[i] = 1'b1;
          else        fp[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (LD) begin
`ifdef OD_MON_RISE_EN
      m_sh = {m_rise, m_fall, m_level};
`else
      m_sh = {m_fall, m_level};
`endif
    end else if (SH) begin
      m_sh = {m_sh[CH-2:0], SI};
    end
    m_fall  = (LD ? {N{1'b0}} : m_fall) | fp;
    m_rise  = (LD ? {N{1'b0}} : m_rise) | rp;
    m_level = nl;
    m_s     = m_s1;
    m_s1    = Y;
  endtask

  // One clock: model consumes the current inputs, DUT sees the edge,
  // outputs are sampled 1 ns later.
  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, " level"}, 32'(LEVEL), 32'(m_level));
    check({tag, " fall"},  32'(FALL),  32'(m_fall));
    check({tag, " q"},     32'(Q),     32'(m_sh[CH-1]));
`ifdef OD_MON_RISE_EN
    check({tag, " rise"},  32'(RISE),  32'(m_rise));
`endif
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [N-1:0] y;
    logic         ld;
    logic         sh;
    logic         si;
    logic [N-1:0] level;
    logic [N-1:0] fall;
    logic         q;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [10:0] qseq;

    CLR_N = 1'b0;
    Y     = '1;
    LD    = 1'b0;
    SH    = 1'b0;
    SI    = 1'b0;
    model_reset();

    // Readout scenario: Y=3A settles (FALL=05), LD, then shift it all out.
    for (int k = 0; k < 5; k++) tbl.push_back('{6'h3A, 1'b0, 1'b0, 1'b0, 6'h3F, 6'h00, 1'b0});
    tbl.push_back('{6'h3A, 1'b0, 1'b0, 1'b0, 6'h3A, 6'h05, 1'b0});
    tbl.push_back('{6'h3A, 1'b1, 1'b0, 1'b0, 6'h3A, 6'h00, 1'b0});
    // RISE bits (all zero) lead the chain when enabled.
    for (int k = 0; k < CH - 2 * N; k++) tbl.push_back('{6'h3A, 1'b0, 1'b1, 1'b0, 6'h3A, 6'h00, 1'b0});
    // Remaining bits of 000101_111010 after the leading 0 already on Q.
    qseq = 11'b00101111010;
    for (int k = 1; k <= 11; k++) tbl.push_back('{6'h3A, 1'b0, 1'b1, 1'b0, 6'h3A, 6'h00, qseq[11-k]});

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("reset level", 32'(LEVEL), 32'h3F);
    check("reset fall",  32'(FALL),  32'h00);
    check("reset q",     32'(Q),     32'h0);
    CLR_N = 1'b1;
    model_reset();

    foreach (tbl[r]) begin
      Y  = tbl[r].y;
      LD = tbl[r].ld;
      SH = tbl[r].sh;
      SI = tbl[r].si;
      tick();
      check($sformatf("tbl%0d level", r), 32'(LEVEL), 32'(tbl[r].level));
      check($sformatf("tbl%0d fall", r),  32'(FALL),  32'(tbl[r].fall));
      check($sformatf("tbl%0d q", r),     32'(Q),     32'(tbl[r].q));
    end
    LD = 1'b0;
    SH = 1'b0;

    // Release lines 0 and 2: levels return high, FALL untouched.
    Y = 6'h3F;
    repeat (6) tick();
    check("release level", 32'(LEVEL), 32'h3F);
    check("release fall",  32'(FALL),  32'h00);
`ifdef OD_MON_RISE_EN
    check("release rise",  32'(RISE),  32'h05);
`endif

    // Glitch of FILTER-1 cycles on Y[0] never reaches LEVEL.
    Y = 6'h3E;
    repeat (FILTER - 1) tick();
    Y = 6'h3F;
    repeat (8) tick();
    check("glitch level", 32'(LEVEL), 32'h3F);
    check("glitch fall",  32'(FALL),  32'h00);

    // Clean fall on Y[2]: LEVEL changes on the 6th edge, FALL on the same edge.
    Y = 6'h3B;
    repeat (5) tick();
    check("fall edge5 level", 32'(LEVEL), 32'h3F);
    check("fall edge5 fall",  32'(FALL),  32'h00);
    tick();
    check("fall edge6 level", 32'(LEVEL), 32'h3B);
    check("fall edge6 fall",  32'(FALL),  32'h04);

    // LD on the edge where Y[5]'s fall commits: snapshot misses it, live keeps it.
    Y = 6'h1B;
    repeat (5) tick();
    LD = 1'b1;
    tick();
    LD = 1'b0;
    check("simul live fall", 32'(FALL),  32'h20);
    check("simul level",     32'(LEVEL), 32'h1B);
    SH = 1'b1;
    for (int k = 0; k < CH - 2 * N; k++) tick();
    SH = 1'b0;
    check("simul snapshot fall5", 32'(Q), 32'h0);
    cmp_model("simul");

    // Async reset in the middle of a readout.
    LD = 1'b1;
    tick();
    LD = 1'b0;
    cmp_model("preclr");
    SH = 1'b1;
    repeat (2) tick();
    CLR_N = 1'b0;
    #2;
    check("midshift clr level", 32'(LEVEL), 32'h3F);
    check("midshift clr fall",  32'(FALL),  32'h00);
    check("midshift clr q",     32'(Q),     32'h0);
`ifdef OD_MON_RISE_EN
    check("midshift clr rise",  32'(RISE),  32'h00);
`endif
    @(posedge CLK);
    #1;
    CLR_N = 1'b1;
    SH    = 1'b0;
    model_reset();

    // Falls then rises on lines 2 and 5, followed by a full readout.
    repeat (6) tick();
    check("refall fall", 32'(FALL), 32'h24);
    Y = 6'h3F;
    repeat (6) tick();
    check("rerise level", 32'(LEVEL), 32'h3F);
`ifdef OD_MON_RISE_EN
    check("rerise rise", 32'(RISE), 32'h24);
`endif
    LD = 1'b1;
    tick();
    LD = 1'b0;
    check("chain msb", 32'(Q), 32'h1);
    SH = 1'b1;
    for (int k = 0; k < CH - 1; k++) begin
      SI = 1'($urandom_range(0, 1));
      tick();
      cmp_model("chain");
    end
    SH = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) Y = N'($urandom);
      else if ($urandom_range(0, 6) == 0) Y = Y ^ N'(1 << $urandom_range(0, N - 1));
      LD = ($urandom_range(0, 11) == 0);
      SH = 1'($urandom_range(0, 1));
      SI = 1'($urandom_range(0, 1));
      tick();
      cmp_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
